// File: rtl/magma_arb_pkg.sv
// Shared types and default constants for the magma memory arbiter.
// rr_pick returns the first requester at or after ptr, wrapping modulo n.
package magma_arb_pkg;

   localparam int N_MST_DEF    = 4;
   localparam int ADDR_W_DEF   = 32;
   localparam int DATA_W_DEF   = 32;
   localparam int RD_DEPTH_DEF = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
      int   pick;
      int   idx;
      logic found;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + i;
         if (idx >= n) idx = idx - n;
         if (!found && (i < n) && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/magma_arb_fifo.sv
// Small synchronous FIFO holding the master index of each outstanding read.
// Push is refused when full and pop is refused when empty.
module magma_arb_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Tag storage carries no reset; only pointers and count are cleared.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/magma_mem_arbiter.sv
// Round-robin arbiter funnelling N_MST masters onto one memory port; read
// responses return in order and are steered back via a tag FIFO.
module magma_mem_arbiter
   import magma_arb_pkg::*;
#(
   parameter int N_MST    = N_MST_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RD_DEPTH = RD_DEPTH_DEF
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [N_MST-1:0]              req_i,
   input  logic [N_MST-1:0]              we_i,
   input  logic [N_MST*ADDR_W-1:0]       addr_i,
   input  logic [N_MST*(DATA_W/8)-1:0]   be_i,
   input  logic [N_MST*DATA_W-1:0]       wdata_i,
   output logic [N_MST-1:0]              ack_o,
   output logic [N_MST-1:0]              resp_o,
   output logic [DATA_W-1:0]             rdata_o,
   output logic                          m_req_o,
   output logic                          m_we_o,
   output logic [ADDR_W-1:0]             m_addr_o,
   output logic [DATA_W/8-1:0]           m_be_o,
   output logic [DATA_W-1:0]             m_wdata_o,
   input  logic                          m_ack_i,
   input  logic                          m_resp_i,
   input  logic [DATA_W-1:0]             m_rdata_i,
   output logic                          err_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = $clog2(N_MST);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] g_q, g_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             err_q, err_d;
   logic             busy, handshake, push, pop;
   logic             fifo_full, fifo_empty;
   logic [IDX_W-1:0] head;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         g_q      <= '0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      rr_ptr_d = rr_ptr_q;
      err_d    = err_q | (m_resp_i & fifo_empty);
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               g_d     = IDX_W'(rr_pick(8'(req_i), int'(rr_ptr_q), N_MST));
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (handshake) begin
               rr_ptr_d = (int'(g_q) == N_MST - 1) ? '0 : g_q + 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Every output is forced low while rst_i is high, whatever the state.
   always_comb begin
      busy      = (state_q == ST_BUSY) && !rst_i;
      m_req_o   = busy && !(!we_i[g_q] && fifo_full);
      m_we_o    = 1'b0;
      m_addr_o  = '0;
      m_be_o    = '0;
      m_wdata_o = '0;
      if (busy) begin
         m_we_o    = we_i[g_q];
         m_addr_o  = addr_i[int'(g_q)*ADDR_W +: ADDR_W];
         m_be_o    = be_i[int'(g_q)*BE_W +: BE_W];
         m_wdata_o = wdata_i[int'(g_q)*DATA_W +: DATA_W];
      end
      handshake = m_req_o && m_ack_i;
      push      = handshake && !we_i[g_q];
      ack_o     = '0;
      if (handshake) ack_o[g_q] = 1'b1;
      pop       = m_resp_i && !fifo_empty && !rst_i;
      resp_o    = '0;
      rdata_o   = '0;
      if (pop) begin
         resp_o[head] = 1'b1;
         rdata_o      = m_rdata_i;
      end
   end

   assign err_o = err_q & ~rst_i;

   magma_arb_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (RD_DEPTH)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (g_q),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_magma_mem_arbiter.sv
// Bench for magma_mem_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_magma_mem_arbiter;

   localparam int N     = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = 4;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_i;
   logic [N-1:0]    req_i, we_i;
   logic [N*AW-1:0] addr_i;
   logic [N*BW-1:0] be_i;
   logic [N*DW-1:0] wdata_i;
   logic [N-1:0]    ack_o, resp_o;
   logic [DW-1:0]   rdata_o;
   logic            m_req_o, m_we_o;
   logic [AW-1:0]   m_addr_o;
   logic [BW-1:0]   m_be_o;
   logic [DW-1:0]   m_wdata_o;
   logic            m_ack_i, m_resp_i;
   logic [DW-1:0]   m_rdata_i;
   logic            err_o;

   always #5 clk = ~clk;

   magma_mem_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .RD_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .be_i(be_i), .wdata_i(wdata_i), .ack_o(ack_o), .resp_o(resp_o),
      .rdata_o(rdata_o), .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
      .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_ack_i(m_ack_i),
      .m_resp_i(m_resp_i), .m_rdata_i(m_rdata_i), .err_o(err_o)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit rereq = 1'b0;

   // reference model: who holds the bus, rotation pointer, pending read owners
   bit mbusy = 1'b0;
   int mg    = 0;
   int mptr  = 0;
   int tags[$];
   bit merr  = 1'b0;

   logic [N-1:0]  last_ack, last_resp;
   logic [DW-1:0] last_rdata;
   logic [AW-1:0] last_addr;
   logic          last_mreq, last_we, last_err;
   int ack_cyc_q[$];
   int ack_idx_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      logic [N-1:0]  e_ack, e_resp;
      logic [DW-1:0] e_rdata, e_wdata;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_be;
      logic          e_mreq, e_we, e_err;
      bit            hs, pop, found;
      int            idx;
      @(negedge clk);
      e_ack = '0; e_resp = '0; e_rdata = '0; e_wdata = '0; e_addr = '0; e_be = '0;
      e_mreq = 1'b0; e_we = 1'b0; e_err = 1'b0; hs = 1'b0; pop = 1'b0;
      if (!rst_i) begin
         if (mbusy) begin
            e_mreq  = we_i[mg] || (tags.size() < DEPTH);
            e_we    = we_i[mg];
            e_addr  = addr_i[mg*AW +: AW];
            e_be    = be_i[mg*BW +: BW];
            e_wdata = wdata_i[mg*DW +: DW];
         end
         hs = e_mreq && m_ack_i;
         if (hs) e_ack[mg] = 1'b1;
         pop = m_resp_i && (tags.size() > 0);
         if (pop) begin
            e_resp[tags[0]] = 1'b1;
            e_rdata = m_rdata_i;
         end
         e_err = merr;
      end
      chk("ack_o", ack_o, e_ack);
      chk("resp_o", resp_o, e_resp);
      chk("rdata_o", rdata_o, e_rdata);
      chk("m_req_o", m_req_o, e_mreq);
      chk("m_we_o", m_we_o, e_we);
      chk("m_addr_o", m_addr_o, e_addr);
      chk("m_be_o", m_be_o, e_be);
      chk("m_wdata_o", m_wdata_o, e_wdata);
      chk("err_o", err_o, e_err);
      last_ack = ack_o; last_resp = resp_o; last_rdata = rdata_o; last_addr = m_addr_o;
      last_mreq = m_req_o; last_we = m_we_o; last_err = err_o;
      for (int k = 0; k < N; k++) begin
         if (ack_o[k]) begin
            ack_cyc_q.push_back(cyc);
            ack_idx_q.push_back(k);
         end
      end
      if (rst_i) begin
         mbusy = 1'b0; mptr = 0; mg = 0; tags.delete(); merr = 1'b0;
      end else begin
         if (m_resp_i && tags.size() == 0) merr = 1'b1;
         if (pop) void'(tags.pop_front());
         if (hs) begin
            if (!e_we) tags.push_back(mg);
            mptr  = (mg + 1) % N;
            mbusy = 1'b0;
         end else if (!mbusy && req_i != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               idx = (mptr + k) % N;
               if (!found && req_i[idx]) begin
                  mg = idx;
                  found = 1'b1;
               end
            end
            mbusy = 1'b1;
         end
      end
      if (!rereq) req_i = req_i & ~ack_o;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input int m, input bit we, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
      req_i[m] = 1'b1;
      we_i[m]  = we;
      addr_i[m*AW +: AW]  = a;
      be_i[m*BW +: BW]    = be;
      wdata_i[m*DW +: DW] = d;
   endtask

   task automatic wait_ack(input int m, input int budget);
      bit got;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         step();
         if (last_ack[m]) got = 1'b1;
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL wait_ack master %0d: no ack within %0d cycles", m, budget);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1; req_i = '0; we_i = '0; m_ack_i = 1'b1;
      m_resp_i = 1'b1; m_rdata_i = '1;
      step();
      chk("rst_zero", {last_ack, last_resp, last_mreq, last_we, last_err}, '0);
      chk("rst_rdata", last_rdata, '0);
      m_resp_i = 1'b0; m_rdata_i = '0;
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      int base, c0;
      rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
      m_ack_i = 1'b1; m_resp_i = 1'b0; m_rdata_i = '0;

      // single read from master 2
      do_reset();
      issue(2, 1'b0, 32'h100, 4'hF, 32'h0);
      step(); chk("s40_ack_c0", last_ack, 4'b0000);
      step(); chk("s40_ack_c1", last_ack, 4'b0100);
      chk("s40_addr", last_addr, 32'h100);
      step();
      m_resp_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
      step(); m_resp_i = 1'b0;
      chk("s40_resp", last_resp, 4'b0100);
      chk("s40_rdata", last_rdata, 32'hDEADBEEF);

      // all masters requesting continuously
      do_reset();
      for (int k = 0; k < N; k++) issue(k, 1'b1, 32'h1000 + k*4, 4'(k + 1), 32'hA000 + k);
      base = ack_idx_q.size(); c0 = cyc; rereq = 1'b1;
      repeat (11) step();
      rereq = 1'b0;
      n_vec++;
      if (ack_idx_q.size() < base + 5) begin
         n_err++;
         $display("FAIL s41_count: got %0d acks required 5", ack_idx_q.size() - base);
      end else begin
         chk("s41_first_cycle", ack_cyc_q[base] - c0, 1);
         for (int k = 0; k < 5; k++) begin
            chk("s41_grant", ack_idx_q[base+k], k % N);
            if (k > 0) chk("s41_gap", ack_cyc_q[base+k] - ack_cyc_q[base+k-1], 2);
         end
      end

      // read FIFO full blocks the fifth read
      do_reset();
      for (int k = 0; k < 4; k++) begin
         issue(0, 1'b0, 32'h200 + k*4, 4'h3, 32'h0);
         wait_ack(0, 6);
      end
      issue(0, 1'b0, 32'h210, 4'h3, 32'h0);
      repeat (4) begin
         step(); chk("s42_blocked", last_mreq, 1'b0);
      end
      m_resp_i = 1'b1; m_rdata_i = 32'hA5;
      step(); m_resp_i = 1'b0;
      chk("s42_pop_resp", last_resp, 4'b0001);
      chk("s42_pop_mreq", last_mreq, 1'b0);
      step();
      chk("s42_issue_mreq", last_mreq, 1'b1);
      chk("s42_issue_ack", last_ack, 4'b0001);
      for (int k = 0; k < 4; k++) begin
         m_resp_i = 1'b1; m_rdata_i = 32'hB0 + k;
         step();
         chk("s42_drain", last_resp, 4'b0001);
      end
      m_resp_i = 1'b0;
      step(); chk("s42_no_err", last_err, 1'b0);

      // in-order responses routed to masters 3 then 1
      do_reset();
      issue(3, 1'b0, 32'h300, 4'hF, 32'h0); wait_ack(3, 4);
      issue(1, 1'b0, 32'h304, 4'hF, 32'h0); wait_ack(1, 4);
      m_resp_i = 1'b1; m_rdata_i = 32'h11;
      step();
      chk("s43_resp3", last_resp, 4'b1000); chk("s43_data3", last_rdata, 32'h11);
      m_rdata_i = 32'h22;
      step(); m_resp_i = 1'b0;
      chk("s43_resp1", last_resp, 4'b0010); chk("s43_data1", last_rdata, 32'h22);

      // unexpected response sets sticky error
      do_reset();
      m_resp_i = 1'b1; m_rdata_i = 32'h55;
      step(); m_resp_i = 1'b0;
      chk("s44_resp", last_resp, 4'b0000);
      repeat (3) begin
         step(); chk("s44_err_held", last_err, 1'b1);
      end
      do_reset();
      step(); chk("s44_err_cleared", last_err, 1'b0);

      // reset while BUSY abandons the request
      do_reset();
      m_ack_i = 1'b0;
      issue(1, 1'b1, 32'h500, 4'hC, 32'hCAFE);
      step(); step();
      chk("s45_busy_mreq", last_mreq, 1'b1);
      chk("s45_busy_addr", last_addr, 32'h500);
      rst_i = 1'b1;
      step();
      chk("s45_rst_outs", {last_ack, last_resp, last_mreq, last_we, last_err}, '0);
      rst_i = 1'b0; req_i = '0; m_ack_i = 1'b1;
      step();
      chk("s45_idle_mreq", last_mreq, 1'b0);
      chk("s45_idle_addr", last_addr, '0);
      issue(0, 1'b1, 32'h504, 4'hF, 32'h1234);
      step(); step();
      chk("s45_ack0", last_ack, 4'b0001);
      chk("s45_addr0", last_addr, 32'h504);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/magma_mem_arbiter.md
MAGMA_MEM_ARBITER -- requirements
Module: magma_mem_arbiter

Interface
REQ-001 SHALL have parameter N_MST, default 4, meaning the number of requesting cores or masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the data width; the byte-enable width BE_W equals DATA_W/8.
REQ-004 SHALL have parameter RD_DEPTH, default 4, meaning the maximum number of outstanding reads (power of 2).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port req_i, input, N_MST bits: per-master request, held until acked.
REQ-008 SHALL have port we_i, input, N_MST bits: per-master write enable.
REQ-009 SHALL have port addr_i, input, N_MST*ADDR_W bits: packed per-master address.
REQ-010 SHALL have port be_i, input, N_MST*BE_W bits: packed per-master byte enables.
REQ-011 SHALL have port wdata_i, input, N_MST*DATA_W bits: packed per-master write data.
REQ-012 SHALL have port ack_o, output, N_MST bits: per-master request accepted.
REQ-013 SHALL have port resp_o, output, N_MST bits: per-master read data valid.
REQ-014 SHALL have port rdata_o, output, DATA_W bits: read data shared by all masters, qualified by resp_o.
REQ-015 SHALL have the following downstream port group, all outputs: m_req_o 1 bit, m_we_o 1 bit, m_addr_o ADDR_W bits, m_be_o BE_W bits, m_wdata_o DATA_W bits.
REQ-016 SHALL have the following downstream port group, all inputs: m_ack_i 1 bit, m_resp_i 1 bit, m_rdata_i DATA_W bits.
REQ-017 SHALL have port err_o, output, 1 bit: sticky flag for an unexpected response.

Function
REQ-018 SHALL implement the FSM states IDLE and BUSY.
REQ-019 SHALL, in IDLE with any req_i bit set, register grant index g as the first requester at or after rr_ptr (wrapping modulo N_MST), then enter BUSY on the next clock edge.
REQ-020 SHALL, in BUSY, drive m_we_o, m_addr_o, m_be_o and m_wdata_o from master g.
REQ-021 SHALL, in BUSY, assert m_req_o unless we_i[g]=0 and the read FIFO is full.
REQ-022 SHALL, when m_req_o and m_ack_i are both high, assert ack_o[g] combinationally in the same cycle.
REQ-023 SHALL, on the same handshake as REQ-022, push g into the read FIFO if the access is a read, set rr_ptr to (g+1) mod N_MST, and return to IDLE.
REQ-024 SHALL achieve a minimum latency of 1 cycle from req_i to m_req_o, and a throughput of one transfer per 2 cycles.
REQ-025 SHALL hold m_req_o and all m_* outputs at 0 in IDLE.
REQ-026 SHALL never assert ack_o for a master other than g.
REQ-027 SHALL assert at most one ack_o bit per cycle.
REQ-028 SHALL, when m_resp_i=1 and the FIFO is non-empty, pop the FIFO head h, assert resp_o[h] for one cycle, and drive rdata_o=m_rdata_i in the same cycle.
REQ-029 SHALL, when m_resp_i=1 and the FIFO is empty, ignore the response (no resp_o bit set) and set err_o=1 until reset.
REQ-030 SHALL, on a simultaneous push and pop when the FIFO is not full, perform both, leaving the count unchanged.
REQ-031 SHALL, when the FIFO is full, block the push even if a pop occurs in the same cycle; the read is issued on the following cycle.
REQ-032 SHALL issue writes without FIFO involvement and regardless of FIFO fill level.
REQ-033 SHALL treat a master dropping req_i before its ack as a protocol violation with undefined behaviour; this is not checked.

Reset
REQ-034 SHALL, with rst_i=1 at a clock edge, set the state to IDLE, g=0, rr_ptr=0, the FIFO empty, and err_o=0.
REQ-035 SHALL hold every output at 0 while in reset, including rdata_o.
REQ-036 SHALL, on reset mid-transaction, abandon the in-flight request without ack and discard all outstanding read tags; the downstream memory is reset alongside.

Structure
REQ-037 SHALL place the FSM state enum and the default parameter constants in shared package magma_arb_pkg.
REQ-038 SHALL implement the tag FIFO as sub-module magma_arb_fifo, parameterized in width and depth, with full, empty, push and pop signals.
REQ-039 SHALL have no other sub-modules.

Verification
REQ-040 SHALL cover the following scenario: single master 2 read at addr 0x100 with downstream ack after 0 wait states and response data 0xDEADBEEF two cycles later -> ack_o=4'b0100 at cycle 1, then resp_o=4'b0100 with rdata_o=0xDEADBEEF.
REQ-041 SHALL cover the following scenario: all 4 masters requesting continuously from reset -> grant order 0,1,2,3,0, with each ack 2 cycles apart.
REQ-042 SHALL cover the following scenario: RD_DEPTH=4 with 5 reads and no responses -> the 5th read keeps m_req_o=0 until one m_resp_i pulse, after which the 5th read is issued.
REQ-043 SHALL cover the following scenario: reads from masters 3 then 1 with in-order responses 0x11 then 0x22 -> resp_o[3] receives 0x11 and resp_o[1] receives 0x22.
REQ-044 SHALL cover the following scenario: m_resp_i pulse with the FIFO empty -> no resp_o bit set, err_o=1 and held until rst_i.
REQ-045 SHALL cover the following scenario: rst_i asserted in BUSY before m_ack_i -> next cycle all outputs are 0, the state is IDLE, and a subsequent request from master 0 is granted normally.
